// File: rtl/bcd_counter_n.sv
// bcd_counter_n: N-digit packed-BCD counter with validated load, wrap/saturate and terminal pulse; BCD_DOWN_EN adds dir
module bcd_counter_n #(
  parameter int DIGITS = 3,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
`ifdef BCD_DOWN_EN
  input  logic                  dir,
`endif
  output logic [4*DIGITS-1:0]   result,
  output logic                  carry,
  output logic                  load_err
);
  logic [4*DIGITS-1:0] result_q, result_d, inc_val, dec_val, step_val;
  logic carry_q, carry_d, err_q, err_d;
  logic load_ok, inc_c, dec_b, down, term;
`ifdef BCD_DOWN_EN
  assign down = dir;
`else
  assign down = 1'b0;
`endif
  // a load is accepted only when every nibble is a legal BCD digit
  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (load_val[4*i+:4] > 4'd9) load_ok = 1'b0;
  end
  // up and down ripple, both resolved in one cycle; leftover carry/borrow marks terminal count
  always_comb begin
    inc_val = result_q;
    dec_val = result_q;
    inc_c   = 1'b1;
    dec_b   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (inc_c) begin
        inc_val[4*i+:4] = (result_q[4*i+:4] == 4'd9) ? 4'd0 : result_q[4*i+:4] + 4'd1;
        inc_c = (result_q[4*i+:4] == 4'd9);
      end
      if (dec_b) begin
        dec_val[4*i+:4] = (result_q[4*i+:4] == 4'd0) ? 4'd9 : result_q[4*i+:4] - 4'd1;
        dec_b = (result_q[4*i+:4] == 4'd0);
      end
    end
  end
  // next state: load beats count, count beats hold; saturation freezes the value at terminal
  always_comb begin
    term     = down ? dec_b : inc_c;
    step_val = down ? dec_val : inc_val;
    result_d = load ? (load_ok ? load_val : result_q)
             : en   ? ((term && !WRAP) ? result_q : step_val)
             : result_q;
    carry_d  = !load && en && term;
    err_d    = load && !load_ok;
  end
  // registered outputs with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
      err_q    <= err_d;
    end
  end
  assign result   = result_q;
  assign carry    = carry_q;
  assign load_err = err_q;
endmodule

// File: tb/tb_bcd_counter_n.sv
// tb_bcd_counter_n: directed checks of wrap, saturate and 1-digit counters
module tb_bcd_counter_n;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_w = 0, ld_w = 0, en_s = 0, ld_s = 0, en_1 = 0, ld_1 = 0;
  logic [11:0] lv_w = '0, lv_s = '0, res_w, res_s;
  logic [3:0] lv_1 = '0, res_1;
  logic cy_w, cy_s, cy_1, er_w, er_s, er_1;
`ifdef BCD_DOWN_EN
  logic dir = 1'b0;
`endif
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  bcd_counter_n #(.DIGITS(3), .WRAP(1'b1)) u_wrap (.clk(clk), .rst_n(rst_n), .en(en_w), .load(ld_w), .load_val(lv_w),
`ifdef BCD_DOWN_EN
    .dir(dir),
`endif
    .result(res_w), .carry(cy_w), .load_err(er_w));
  bcd_counter_n #(.DIGITS(3), .WRAP(1'b0)) u_sat (.clk(clk), .rst_n(rst_n), .en(en_s), .load(ld_s), .load_val(lv_s),
`ifdef BCD_DOWN_EN
    .dir(dir),
`endif
    .result(res_s), .carry(cy_s), .load_err(er_s));
  bcd_counter_n #(.DIGITS(1), .WRAP(1'b1)) u_one (.clk(clk), .rst_n(rst_n), .en(en_1), .load(ld_1), .load_val(lv_1),
`ifdef BCD_DOWN_EN
    .dir(dir),
`endif
    .result(res_1), .carry(cy_1), .load_err(er_1));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_w(input string name, input logic [11:0] r, input logic c, input logic e);
    total++;
    if (res_w !== r || cy_w !== c || er_w !== e) begin
      bad++;
      $display("FAIL %s: got result=%h carry=%b load_err=%b, want result=%h carry=%b load_err=%b", name, res_w, cy_w, er_w, r, c, e);
    end
  endtask
  task automatic test_reset();
    #3;
    total++;
    if (res_w !== 12'h000 || cy_w !== 1'b0 || er_w !== 1'b0 || res_s !== 12'h000 || res_1 !== 4'h0) begin
      bad++;
      $display("FAIL reset: got w=%h/%b/%b s=%h one=%h, want 000/0/0 000 0", res_w, cy_w, er_w, res_s, res_1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask
  task automatic test_count();
    int carries = 0;
    en_w = 1;
    step();
    chk_w("count_first", 12'h001, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) begin
      step();
      if (cy_w) carries++;
    end
    en_w = 0;
    chk_w("count_ten", 12'h010, 1'b0, 1'b0);
    total++;
    if (carries !== 0) begin
      bad++;
      $display("FAIL count_carry: got %0d carry cycles, want 0", carries);
    end
    step();
    chk_w("count_hold", 12'h010, 1'b0, 1'b0);
  endtask
  task automatic test_wrap();
    ld_w = 1; lv_w = 12'h998;
    step();
    ld_w = 0; en_w = 1;
    chk_w("wrap_load", 12'h998, 1'b0, 1'b0);
    step();
    chk_w("wrap_999", 12'h999, 1'b0, 1'b0);
    step();
    en_w = 0;
    chk_w("wrap_000", 12'h000, 1'b1, 1'b0);
    step();
    chk_w("wrap_after", 12'h000, 1'b0, 1'b0);
    ld_w = 1; lv_w = 12'h199; en_w = 0;
    step();
    ld_w = 0; en_w = 1;
    step();
    en_w = 0;
    chk_w("ripple_200", 12'h200, 1'b0, 1'b0);
  endtask
  task automatic test_saturate();
    ld_s = 1; lv_s = 12'h999;
    step();
    ld_s = 0; en_s = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (res_s !== 12'h999 || cy_s !== 1'b1) begin
        bad++;
        $display("FAIL sat_%0d: got result=%h carry=%b, want 999/1", i, res_s, cy_s);
      end
    end
    en_s = 0;
    step();
    total++;
    if (res_s !== 12'h999 || cy_s !== 1'b0) begin
      bad++;
      $display("FAIL sat_idle: got result=%h carry=%b, want 999/0", res_s, cy_s);
    end
  endtask
  task automatic test_load_err();
    ld_w = 1; lv_w = 12'h057;
    step();
    lv_w = 12'h1A3; en_w = 1;
    step();
    chk_w("err_mid", 12'h057, 1'b0, 1'b1);
    lv_w = 12'h123;
    step();
    chk_w("load_wins", 12'h123, 1'b0, 1'b0);
    ld_w = 0;
    step();
    en_w = 0;
    chk_w("count_after_load", 12'h124, 1'b0, 1'b0);
    ld_w = 1; lv_w = 12'hF00;
    step();
    ld_w = 0;
    chk_w("err_top", 12'h124, 1'b0, 1'b1);
    step();
    chk_w("err_clears", 12'h124, 1'b0, 1'b0);
  endtask
`ifdef BCD_DOWN_EN
  task automatic test_down();
    dir = 1; ld_w = 1; lv_w = 12'h100;
    step();
    ld_w = 0; en_w = 1;
    step();
    en_w = 0;
    chk_w("down_borrow", 12'h099, 1'b0, 1'b0);
    ld_w = 1; lv_w = 12'h000;
    step();
    ld_w = 0; en_w = 1;
    step();
    en_w = 0;
    chk_w("down_wrap", 12'h999, 1'b1, 1'b0);
    ld_s = 1; lv_s = 12'h000;
    step();
    ld_s = 0; en_s = 1;
    step();
    en_s = 0;
    total++;
    if (res_s !== 12'h000 || cy_s !== 1'b1) begin
      bad++;
      $display("FAIL down_sat: got result=%h carry=%b, want 000/1", res_s, cy_s);
    end
    dir = 0; en_w = 1;
    step();
    en_w = 0;
    chk_w("dir_switch", 12'h000, 1'b1, 1'b0);
  endtask
`endif
  task automatic test_async_reset();
    ld_w = 1; lv_w = 12'h057;
    step();
    ld_w = 0;
    chk_w("pre_reset", 12'h057, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_w("async_clear", 12'h000, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    en_w = 1;
    step();
    en_w = 0;
    chk_w("resume", 12'h001, 1'b0, 1'b0);
  endtask
  task automatic test_one_digit();
    ld_1 = 1; lv_1 = 4'h9;
    step();
    ld_1 = 0; en_1 = 1;
    step();
    en_1 = 0;
    total++;
    if (res_1 !== 4'h0 || cy_1 !== 1'b1) begin
      bad++;
      $display("FAIL one_wrap: got result=%h carry=%b, want 0/1", res_1, cy_1);
    end
    ld_1 = 1; lv_1 = 4'hA;
    step();
    ld_1 = 0;
    total++;
    if (res_1 !== 4'h0 || er_1 !== 1'b1 || cy_1 !== 1'b0) begin
      bad++;
      $display("FAIL one_err: got result=%h load_err=%b carry=%b, want 0/1/0", res_1, er_1, cy_1);
    end
  endtask
  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_saturate();
    test_load_err();
`ifdef BCD_DOWN_EN
    test_down();
`endif
    test_async_reset();
    test_one_digit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
